// File: rtl/mem_defs.sv
// rtl/mem_defs.sv - shared FSM encodings and default sizing for the data memory responder
package mem_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_ST = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam int DEFAULT_WAIT  = 2;
  localparam int DEFAULT_DEPTH = 64;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage with one synchronous write port, combinational read, synchronous clear
module mem_array #(
  parameter int datasize = 32,
  parameter int DEPTH    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [datasize-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [datasize-1:0]      rdata
);

  logic [datasize-1:0] mem [DEPTH];

  // Clear wins over a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated load/store responder in front of a word memory
module data_mem_responder
  import mem_defs::*;
#(
  parameter int datasize = 32,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int WAIT     = DEFAULT_WAIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [datasize-1:0] req_addr,
  input  logic [datasize-1:0] req_wdata,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [datasize-1:0] rsp_rdata,
  output logic                rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t              state;
  state_t              state_nx;
  logic [3:0]          cnt;
  logic                cap_we;
  logic [datasize-1:0] cap_addr;
  logic [datasize-1:0] cap_wdata;
  logic                accept;
  logic                addr_err;
  logic                mem_we;
  logic [AW-1:0]       word_idx;
  logic [datasize-1:0] word_num;
  logic [datasize-1:0] mem_rdata;

  assign accept   = req_valid && (state == IDLE);
  assign word_idx = cap_addr[AW+1:2];
  assign word_num = {2'b00, cap_addr[datasize-1:2]};
  assign addr_err = (cap_addr[1:0] != 2'b00) || (word_num >= datasize'(DEPTH));
  // Store commits on the edge that leaves RESP, so a back-to-back load sees it.
  assign mem_we   = (state == RESP) && cap_we && !addr_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cnt       <= WAIT_LOAD;
      end else if (state == WAIT_ST && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (WAIT == 0) ? RESP : WAIT_ST;
      WAIT_ST: if (cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    if (state == RESP) begin
      rsp_valid = 1'b1;
      rsp_err   = addr_err;
      rsp_rdata = (!cap_we && !addr_err) ? mem_rdata : '0;
    end
  end

  mem_array #(
    .datasize(datasize),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (mem_we),
    .waddr(word_idx),
    .wdata(cap_wdata),
    .raddr(word_idx),
    .rdata(mem_rdata)
  );

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter datasize, default 32, giving the data and address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, giving the number of storage words (power of two, at least 2).
REQ-003 The block SHALL have parameter WAIT, default 2, giving the number of wait-state cycles inserted per access (0 to 15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: the initiator presents an access.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, datasize bits: byte address (ALU result).
REQ-009 The block SHALL have port req_wdata, input, datasize bits: store data (register-file read port 2).
REQ-010 The block SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port rsp_rdata, output, datasize bits: load data, valid while rsp_valid is high.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: access rejected, valid while rsp_valid is high.

Function
REQ-014 The block SHALL implement FSM states IDLE, WAIT_ST and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; it SHALL be combinational from state only.
REQ-016 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; req_we, req_addr and req_wdata SHALL be captured in internal registers at that edge.
REQ-017 On accept, the FSM SHALL go to WAIT_ST with the wait counter loaded to WAIT-1 when WAIT>0, or directly to RESP when WAIT=0.
REQ-018 In WAIT_ST the counter SHALL decrement each cycle; the FSM SHALL go to RESP on the edge where the counter equals 0.
REQ-019 rsp_valid SHALL be 1 exactly in RESP, i.e. WAIT+1 cycles after the accept edge, for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-020 Word index SHALL be captured addr[log2(DEPTH)+1:2]; an access is an error if captured addr[1:0]!=0 or captured addr[datasize-1:2] >= DEPTH.
REQ-021 In RESP for a valid load, rsp_rdata SHALL equal the addressed word; rsp_err=0.
REQ-022 For a valid store, the word SHALL be written on the edge ending RESP; rsp_rdata SHALL be 0 and rsp_err=0.
REQ-023 For an error access, no write SHALL occur, rsp_rdata SHALL be 0 and rsp_err=1.
REQ-024 Outside RESP, rsp_valid, rsp_err and rsp_rdata SHALL be 0.
REQ-025 Input changes after accept SHALL NOT affect the in-flight access.
REQ-026 A load from a word immediately after a store to it SHALL return the stored value, since the store commits before the next accept can occur.

Reset
REQ-027 While reset=1 at an edge, the FSM SHALL go to IDLE, the counter and captured registers SHALL clear to 0, and all storage words SHALL clear to 0.
REQ-028 Reset SHALL take priority over any accept, countdown or write; a reset during WAIT_ST or RESP SHALL abort the access, and no write SHALL occur.
REQ-029 In the first cycle after reset deasserts: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.

Structure
REQ-030 The state encodings (IDLE=2'd0, WAIT_ST=2'd1, RESP=2'd2) and the default WAIT and DEPTH SHALL live in the shared package/include file mem_defs.
REQ-031 Storage SHALL be a sub-module mem_array (DEPTH x datasize, one synchronous write port, one combinational read port, synchronous clear); the FSM and counter SHALL stay in the top module.

Verification
REQ-032 Use WAIT=2. Store 0xDEADBEEF to address 0x10 accepted at cycle 0 -> rsp_valid at cycle 3 with rsp_err=0; a following load of 0x10 -> rsp_rdata=0xDEADBEEF.
REQ-033 Load from address 0x12 (misaligned) and a store to address 0x100 with DEPTH=64 -> rsp_err=1 and rsp_rdata=0; a reload of word 0x100's alias 0x0 is unchanged.
REQ-034 Hold req_valid high continuously -> accepts occur every WAIT+2=4 cycles, and req_ready=0 in the cycles between.
REQ-035 Assert reset for one cycle during WAIT_ST of a store to 0x20 -> no rsp_valid, a load of 0x20 returns 0, and req_ready=1 in the cycle after reset.
REQ-036 With WAIT=0, store 0x1 to 0x4 then load 0x4 -> each rsp_valid 1 cycle after accept; the load returns 0x00000001.
